alu_mc: RTL

Multi-cycle, parametrised successor to the basic-computer ALU. It executes the single-cycle accumulator operations (add, and, load, complement, circulate through E) plus subtract, unsigned multiply and unsigned divide, which run iteratively over WIDTH cycles. A start/busy/done handshake sits between the control sequencer and the AC/E registers. All outputs are registered and hold their values until the next completed operation.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_muldiv.sv | 61 ++++++
 rtl/alu_mc.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and E-control encodings for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_AND = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_CMA = 4'h3;
  localparam logic [3:0] OP_CIR = 4'h4;
  localparam logic [3:0] OP_CIL = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_NOP = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;
  localparam logic [3:0] OP_DIV = 4'h9;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  localparam logic [1:0] E_SET = 2'b10;
  localparam logic [1:0] E_CLR = 2'b01;
  localparam logic [1:0] E_NOP = 2'b11;

  // Divide by zero bypasses the iterative datapath.
  function automatic logic needs_iter(input logic [3:0] op, input logic div_by_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !div_by_zero);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per step.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             last
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opb;
  logic             div_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Multiply keeps {hi,lo} as the running product; divide keeps remainder in hi, quotient in lo.
  assign mul_sum = {1'b0, hi} + {1'b0, (lo[0] ? opb : '0)};
  assign shifted = {hi, lo[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, opb});
  assign diff    = shifted[WIDTH-1:0] - opb;
  assign last    = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      opb   <= '0;
      div_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else if (load) begin
      cnt   <= CW'(WIDTH);
      opb   <= b;
      div_q <= is_div;
      hi    <= '0;
      lo    <= a;
    end else if (step && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
      if (div_q) begin
        hi <= ge ? diff : shifted[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], ge};
      end else begin
        hi <= mul_sum[WIDTH:1];
        lo <= {mul_sum[0], lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle accumulator ALU: single-cycle AC ops plus iterative MUL/DIV behind a start/busy/done handshake.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opsel,
  input  logic [WIDTH-1:0] ac,
  input  logic [WIDTH-1:0] dr,
  input  logic             e_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             co,
  output logic             ovf,
  output logic             n,
  output logic             z,
  output logic [1:0]       cntrl_e
);

  state_e           state, state_nxt;
  logic             accept, md_load, md_step, md_last;
  logic [WIDTH-1:0] md_lo, md_hi;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, d_q;
  logic             e_q;
  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_c, hi_c;
  logic             co_c, ovf_c;
  logic [1:0]       ce_c;

  // The first ITER cycle still shows busy=0, so ITER itself also blocks acceptance.
  assign accept = start && !busy && (state != ITER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    md_load   = 1'b0;
    md_step   = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (accept) begin
          if (needs_iter(opsel, dr == '0)) begin
            state_nxt = ITER;
            md_load   = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      ITER: begin
        md_step = 1'b1;
        if (md_last) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= OP_NOP;
      a_q  <= '0;
      d_q  <= '0;
      e_q  <= 1'b0;
    end else if (accept) begin
      op_q <= opsel;
      a_q  <= ac;
      d_q  <= dr;
      e_q  <= e_in;
    end
  end

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (md_load),
    .step   (md_step),
    .is_div (opsel == OP_DIV),
    .a      (ac),
    .b      (dr),
    .lo     (md_lo),
    .hi     (md_hi),
    .last   (md_last)
  );

  // Subtract reuses the adder as a + ~d + 1.
  assign is_sub = (op_q == OP_SUB);
  assign b_op   = is_sub ? ~d_q : d_q;
  assign sum    = {1'b0, a_q} + {1'b0, b_op} + (WIDTH + 1)'(is_sub);

  always_comb begin
    res_c = a_q;
    hi_c  = '0;
    co_c  = 1'b0;
    ovf_c = 1'b0;
    ce_c  = E_NOP;
    case (op_q)
      OP_ADD, OP_SUB: begin
        res_c = sum[WIDTH-1:0];
        co_c  = sum[WIDTH];
        ovf_c = (a_q[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
        ce_c  = co_c ? E_SET : E_CLR;
      end
      OP_AND: res_c = a_q & d_q;
      OP_LDA: res_c = d_q;
      OP_CMA: res_c = ~a_q;
      OP_CIR: begin
        res_c = {e_q, a_q[WIDTH-1:1]};
        co_c  = a_q[0];
        ce_c  = co_c ? E_SET : E_CLR;
      end
      OP_CIL: begin
        res_c = {a_q[WIDTH-2:0], e_q};
        co_c  = a_q[WIDTH-1];
        ce_c  = co_c ? E_SET : E_CLR;
      end
      OP_MUL: begin
        res_c = md_lo;
        hi_c  = md_hi;
        co_c  = (md_hi != '0);
        ovf_c = co_c;
      end
      OP_DIV: begin
        if (d_q == '0) begin
          res_c = '1;
          hi_c  = a_q;
          ovf_c = 1'b1;
        end else begin
          res_c = md_lo;
          hi_c  = md_hi;
        end
      end
      default: ;
    endcase
  end

  // Results are captured only on the edge leaving DONE; they hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
      n         <= 1'b0;
      z         <= 1'b0;
      cntrl_e   <= E_NOP;
    end else begin
      busy <= (state == ITER);
      done <= (state == DONE);
      if (state == DONE) begin
        result    <= res_c;
        result_hi <= hi_c;
        co        <= co_c;
        ovf       <= ovf_c;
        n         <= res_c[WIDTH-1];
        z         <= (res_c == '0);
        cntrl_e   <= ce_c;
      end
    end
  end

endmodule
